// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// axi_sram_slave : AXI3-style 64-bit flop-array responder (on-chip scratch RAM)
// Rev 1.0 : one outstanding write and one outstanding read burst
// ============================================================================
module axi_sram_slave #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 1024,
   parameter logic [7:0]  B_ID      = 8'h00
) (
   input  logic        acr_clk,
   input  logic        acr_rst,
   input  logic [31:0] axi_awaddr,
   input  logic [3:0]  axi_awlen,
   input  logic [2:0]  axi_awsize,
   input  logic [1:0]  axi_awburst,
   input  logic        axi_awlock,
   input  logic [3:0]  axi_awcache,
   input  logic [2:0]  axi_awprot,
   input  logic        axi_awvalid,
   output logic        axi_awready,
   input  logic [63:0] axi_wdata,
   input  logic [7:0]  axi_wstrb,
   input  logic        axi_wlast,
   input  logic        axi_wvalid,
   output logic        axi_wready,
   output logic [7:0]  axi_bid,
   output logic [1:0]  axi_bresp,
   output logic        axi_bvalid,
   input  logic        axi_bready,
   input  logic [7:0]  axi_arid,
   input  logic [31:0] axi_araddr,
   input  logic [3:0]  axi_arlen,
   input  logic [2:0]  axi_arsize,
   input  logic [1:0]  axi_arburst,
   input  logic        axi_arlock,
   input  logic [3:0]  axi_arcache,
   input  logic [2:0]  axi_arprot,
   input  logic        axi_arvalid,
   output logic        axi_arready,
   output logic [7:0]  axi_rid,
   output logic [63:0] axi_rdata,
   output logic [1:0]  axi_rresp,
   output logic        axi_rlast,
   output logic        axi_rvalid,
   input  logic        axi_rready
);

   localparam int          c_AW     = $clog2(DEPTH);
   localparam logic [31:0] c_SPAN   = 32'(DEPTH * 8);
   localparam logic [1:0]  c_OKAY   = 2'b00;
   localparam logic [1:0]  c_SLVERR = 2'b10;
   localparam logic [1:0]  c_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

   function automatic logic in_range(input logic [31:0] a);
      logic [32:0] d;
      d = {1'b0, a} - {1'b0, BASE_ADDR};
      return !d[32] && (d[31:0] < c_SPAN);
   endfunction

   function automatic logic [c_AW-1:0] word_idx(input logic [31:0] a);
      return c_AW'((a - BASE_ADDR) >> 3);
   endfunction

   function automatic logic wrap_ok(input logic [3:0] len);
      return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
   endfunction

   function automatic logic burst_err(input logic [2:0] size, input logic [3:0] len,
                                      input logic [1:0] burst);
      return (size > 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len));
   endfunction

   // Illegal burst encodings degrade to INCR so the beat walk stays well defined.
   function automatic logic [1:0] eff_burst(input logic [3:0] len, input logic [1:0] burst);
      return ((burst == 2'b11) || ((burst == 2'b10) && !wrap_ok(len))) ? 2'b01 : burst;
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step;
      logic [31:0] mask;
      step = 32'd1 << size;
      mask = ((32'(len) + 32'd1) << size) - 32'd1;
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~mask) | ((a + step) & mask);
         default: return a + step;
      endcase
   endfunction

   logic [63:0] r_mem [DEPTH];

   wstate_t     r_wstate;
   logic [31:0] r_aw_addr;
   logic [3:0]  r_aw_len;
   logic [2:0]  r_aw_size;
   logic [1:0]  r_aw_burst;
   logic [3:0]  r_wcnt;
   logic [1:0]  r_wresp;

   logic        w_wbeat;
   logic        w_wr_inr;
   logic [1:0]  w_wbeat_resp;
   logic [1:0]  w_wresp_acc;

   assign w_wbeat      = (r_wstate == W_DATA) && axi_wvalid && axi_wready;
   assign w_wr_inr     = in_range(r_aw_addr);
   assign w_wbeat_resp = !w_wr_inr ? c_DECERR :
                         (axi_wlast != (r_wcnt == r_aw_len)) ? c_SLVERR : c_OKAY;
   assign w_wresp_acc  = (w_wbeat_resp > r_wresp) ? w_wbeat_resp : r_wresp;

   always_ff @(posedge acr_clk or negedge acr_rst) begin
      if (!acr_rst) begin
         r_wstate    <= W_IDLE;
         r_aw_addr   <= '0;
         r_aw_len    <= '0;
         r_aw_size   <= '0;
         r_aw_burst  <= '0;
         r_wcnt      <= '0;
         r_wresp     <= c_OKAY;
         axi_awready <= 1'b0;
         axi_wready  <= 1'b0;
         axi_bvalid  <= 1'b0;
         axi_bresp   <= c_OKAY;
         axi_bid     <= '0;
      end else begin
         axi_bid <= B_ID;
         case (r_wstate)
            W_IDLE: begin
               axi_awready <= 1'b1;
               if (axi_awvalid && axi_awready) begin
                  r_aw_addr   <= axi_awaddr;
                  r_aw_len    <= axi_awlen;
                  r_aw_size   <= axi_awsize;
                  r_aw_burst  <= eff_burst(axi_awlen, axi_awburst);
                  r_wcnt      <= '0;
                  r_wresp     <= burst_err(axi_awsize, axi_awlen, axi_awburst) ? c_SLVERR : c_OKAY;
                  axi_awready <= 1'b0;
                  axi_wready  <= 1'b1;
                  r_wstate    <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_wbeat) begin
                  r_wresp <= w_wresp_acc;
                  if (r_wcnt == r_aw_len) begin
                     axi_wready <= 1'b0;
                     axi_bvalid <= 1'b1;
                     axi_bresp  <= w_wresp_acc;
                     r_wstate   <= W_RESP;
                  end else begin
                     r_wcnt    <= r_wcnt + 4'd1;
                     r_aw_addr <= next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
                  end
               end
            end
            W_RESP: begin
               if (axi_bready) begin
                  axi_bvalid  <= 1'b0;
                  axi_bresp   <= c_OKAY;
                  axi_awready <= 1'b1;
                  r_wstate    <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // Storage has no reset; out-of-range beats are simply not stored.
   always_ff @(posedge acr_clk) begin
      if (w_wbeat && w_wr_inr) begin
         for (int b = 0; b < 8; b++) begin
            if (axi_wstrb[b]) r_mem[word_idx(r_aw_addr)][b*8 +: 8] <= axi_wdata[b*8 +: 8];
         end
      end
   end

   rstate_t     r_rstate;
   logic [31:0] r_ar_addr;
   logic [3:0]  r_ar_len;
   logic [2:0]  r_ar_size;
   logic [1:0]  r_ar_burst;
   logic [3:0]  r_rcnt;
   logic        r_rerr;

   logic [31:0] w_raddr;
   logic        w_rslv;
   logic        w_rinr;
   logic [63:0] w_rword;

   // Address of the beat to be presented on the next edge: the AR address
   // when idle, otherwise the successor of the beat currently on the bus.
   assign w_raddr = (r_rstate == R_IDLE) ? axi_araddr
                                         : next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
   assign w_rslv  = (r_rstate == R_IDLE) ? burst_err(axi_arsize, axi_arlen, axi_arburst) : r_rerr;
   assign w_rinr  = in_range(w_raddr);
   assign w_rword = w_rinr ? r_mem[word_idx(w_raddr)] : 64'd0;

   always_ff @(posedge acr_clk or negedge acr_rst) begin
      if (!acr_rst) begin
         r_rstate    <= R_IDLE;
         r_ar_addr   <= '0;
         r_ar_len    <= '0;
         r_ar_size   <= '0;
         r_ar_burst  <= '0;
         r_rcnt      <= '0;
         r_rerr      <= 1'b0;
         axi_arready <= 1'b0;
         axi_rvalid  <= 1'b0;
         axi_rid     <= '0;
         axi_rdata   <= '0;
         axi_rresp   <= c_OKAY;
         axi_rlast   <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               axi_arready <= 1'b1;
               if (axi_arvalid && axi_arready) begin
                  r_ar_addr   <= axi_araddr;
                  r_ar_len    <= axi_arlen;
                  r_ar_size   <= axi_arsize;
                  r_ar_burst  <= eff_burst(axi_arlen, axi_arburst);
                  r_rcnt      <= '0;
                  r_rerr      <= w_rslv;
                  axi_arready <= 1'b0;
                  axi_rvalid  <= 1'b1;
                  axi_rid     <= axi_arid;
                  axi_rdata   <= w_rword;
                  axi_rresp   <= !w_rinr ? c_DECERR : (w_rslv ? c_SLVERR : c_OKAY);
                  axi_rlast   <= (axi_arlen == 4'd0);
                  r_rstate    <= R_DATA;
               end
            end
            R_DATA: begin
               if (axi_rready) begin
                  if (axi_rlast) begin
                     axi_rvalid  <= 1'b0;
                     axi_rlast   <= 1'b0;
                     axi_rdata   <= '0;
                     axi_rresp   <= c_OKAY;
                     axi_rid     <= '0;
                     axi_arready <= 1'b1;
                     r_rstate    <= R_IDLE;
                  end else begin
                     r_ar_addr <= w_raddr;
                     r_rcnt    <= r_rcnt + 4'd1;
                     axi_rdata <= w_rword;
                     axi_rresp <= !w_rinr ? c_DECERR : (w_rslv ? c_SLVERR : c_OKAY);
                     axi_rlast <= ((r_rcnt + 4'd1) == r_ar_len);
                  end
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   logic w_unused;
   assign w_unused = &{1'b0, axi_awlock, axi_awcache, axi_awprot,
                       axi_arlock, axi_arcache, axi_arprot};

endmodule
`default_nettype wire
